keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad, debounces it, and drives the 8-bit `key` bus consumed by the alarm-clock controller.
- Emits the keypad keycode protocol from keycodes.vh:
  - make code, held for as long as the key is down;
  - then one cycle of `KP_KEY_RELEASED`;
  - then one cycle of the break code (the released key's code);
  - then `KP_INVALID` (8'h00) while idle.
- Sits between the keypad pins and the controller; both run on clk256.

---
 rtl/keypad_scanner.sv | 258 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and keycode protocol.
// Emits make code while held, then one cycle KP_KEY_RELEASED, one cycle of the
// break code, then KP_INVALID while idle.
// Optional build macro: KPSCAN_STUCK_TIMEOUT_EN (stuck-key timeout + lockout).
module keypad_scanner #(
    parameter int unsigned SCAN_TICKS     = 3,
    parameter int unsigned DEBOUNCE_SCANS = 2,
    parameter int unsigned STUCK_SCANS    = 640
) (
    input  logic       clk256,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] key,
    output logic       key_down
);

    localparam logic [7:0] KP_INVALID      = 8'h00;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
    localparam logic [7:0] KP_0            = 8'h30;
    localparam logic [7:0] KP_STAR         = 8'h2A;
    localparam logic [7:0] KP_MINUS        = 8'h2D;

    localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_PRESS,
        S_PRESSED,
        S_DB_RELEASE,
        S_SEND_REL,
        S_SEND_BRK
`ifdef KPSCAN_STUCK_TIMEOUT_EN
        , S_LOCKOUT
`endif
    } state_t;

    state_t          state, state_nx;
    logic [3:0]      row_s1, row_s2;
    logic [TW-1:0]   tick;
    logic [1:0]      col;
    logic [11:0]     scan_map;
    logic [3:0]      pos, pos_nx;
    logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
    logic [3:0]      cand;
    logic            cand_valid;
    logic            present;
    logic            slot_end, scan_end;
    logic [7:0]      key_nx;
    logic            key_down_nx;

    // Position index is col*4+row; only columns 0..2 carry mapped keys.
    function automatic logic [7:0] code_of(input logic [3:0] p);
        case (p)
            4'd0:    code_of = KP_0 + 8'd1;
            4'd1:    code_of = KP_0 + 8'd4;
            4'd2:    code_of = KP_0 + 8'd7;
            4'd3:    code_of = KP_STAR;
            4'd4:    code_of = KP_0 + 8'd2;
            4'd5:    code_of = KP_0 + 8'd5;
            4'd6:    code_of = KP_0 + 8'd8;
            4'd7:    code_of = KP_0;
            4'd8:    code_of = KP_0 + 8'd3;
            4'd9:    code_of = KP_0 + 8'd6;
            4'd10:   code_of = KP_0 + 8'd9;
            4'd11:   code_of = KP_MINUS;
            default: code_of = KP_INVALID;
        endcase
    endfunction

    assign slot_end = (tick == TW'(SCAN_TICKS - 1));
    assign scan_end = slot_end && (col == 2'd3);
    assign present  = scan_map[pos];
    assign cnt_inc  = (cnt == CW'(DEBOUNCE_SCANS)) ? cnt : cnt + CW'(1);

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
        end
    end

    // Column slot timer, column drive rotation and per-column row capture.
    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            tick     <= '0;
            col      <= '0;
            col_n    <= 4'b1110;
            scan_map <= '0;
        end else if (slot_end) begin
            tick  <= '0;
            col   <= col + 2'd1;
            col_n <= {col_n[2:0], col_n[3]};
            case (col)
                2'd0:    scan_map[3:0]  <= ~row_s2;
                2'd1:    scan_map[7:4]  <= ~row_s2;
                2'd2:    scan_map[11:8] <= ~row_s2;
                default: ;
            endcase
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // First pressed mapped position in scan order (lowest index wins).
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (scan_map[i] && !cand_valid) begin
                cand_valid = 1'b1;
                cand       = 4'(i);
            end
        end
    end

`ifdef KPSCAN_STUCK_TIMEOUT_EN
    localparam int unsigned SW = $clog2(STUCK_SCANS + 1);
    logic [SW-1:0] stuck_cnt;
    logic          stuck_hit;
    logic          lock_pend;

    assign stuck_hit = scan_end && present && (stuck_cnt == SW'(STUCK_SCANS - 1));

    // Scan counter runs only while PRESSED, so it is zero on every entry.
    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            stuck_cnt <= '0;
            lock_pend <= 1'b0;
        end else begin
            if (state != S_PRESSED)
                stuck_cnt <= '0;
            else if (scan_end && present && stuck_cnt != SW'(STUCK_SCANS))
                stuck_cnt <= stuck_cnt + SW'(1);
            if (state == S_PRESSED && stuck_hit)
                lock_pend <= 1'b1;
            else if (state == S_SEND_BRK)
                lock_pend <= 1'b0;
        end
    end
`endif

    // State, latched position, debounce counter and registered outputs.
    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pos      <= '0;
            cnt      <= '0;
            key      <= KP_INVALID;
            key_down <= 1'b0;
        end else begin
            state    <= state_nx;
            pos      <= pos_nx;
            cnt      <= cnt_nx;
            key      <= key_nx;
            key_down <= key_down_nx;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // change on the same edge as the state.
    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (scan_end && cand_valid) begin
                    pos_nx = cand;
                    cnt_nx = CW'(1);
                    if (DEBOUNCE_SCANS <= 1) state_nx = S_PRESSED;
                    else                     state_nx = S_DB_PRESS;
                end
            end
            S_DB_PRESS: begin
                if (scan_end) begin
                    if (present) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc >= CW'(DEBOUNCE_SCANS)) state_nx = S_PRESSED;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = S_IDLE;
                    end
                end
            end
            S_PRESSED: begin
                if (scan_end) begin
                    if (!present) begin
                        cnt_nx = CW'(1);
                        if (DEBOUNCE_SCANS <= 1) state_nx = S_SEND_REL;
                        else                     state_nx = S_DB_RELEASE;
                    end
`ifdef KPSCAN_STUCK_TIMEOUT_EN
                    else if (stuck_hit) begin
                        state_nx = S_SEND_REL;
                    end
`endif
                end
            end
            S_DB_RELEASE: begin
                if (scan_end) begin
                    if (present) begin
                        cnt_nx   = '0;
                        state_nx = S_PRESSED;
                    end else begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc >= CW'(DEBOUNCE_SCANS)) state_nx = S_SEND_REL;
                    end
                end
            end
            S_SEND_REL: state_nx = S_SEND_BRK;
            S_SEND_BRK: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
`ifdef KPSCAN_STUCK_TIMEOUT_EN
                if (lock_pend) state_nx = S_LOCKOUT;
`endif
            end
`ifdef KPSCAN_STUCK_TIMEOUT_EN
            S_LOCKOUT: begin
                if (scan_end) begin
                    if (present) begin
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
                            cnt_nx   = '0;
                            state_nx = S_IDLE;
                        end
                    end
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode from next state and next latched position.
    always_comb begin
        key_nx      = KP_INVALID;
        key_down_nx = 1'b0;
        case (state_nx)
            S_PRESSED, S_DB_RELEASE: begin
                key_nx      = code_of(pos_nx);
                key_down_nx = 1'b1;
            end
            S_SEND_REL: key_nx = KP_KEY_RELEASED;
            S_SEND_BRK: key_nx = code_of(pos_nx);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed steps from the test plan
// followed by random key patterns, checked every cycle against a scan-level
// behavioural model.
module tb_keypad_scanner;

    localparam int unsigned ST  = 3;
    localparam int unsigned DB  = 2;
    localparam int unsigned STK = 4;
    localparam int unsigned NS  = 4 * ST;

    localparam logic [7:0] KP_INVALID      = 8'h00;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
    localparam logic [7:0] KP_STAR         = 8'h2A;
    localparam logic [7:0] KP_MINUS        = 8'h2D;
    // Keycode per bit index col*4+row: columns "147*", "2580", "369#".
    localparam logic [7:0] KC_TAB [12] = '{8'h31, 8'h34, 8'h37, 8'h2A,
                                          8'h32, 8'h35, 8'h38, 8'h30,
                                          8'h33, 8'h36, 8'h39, 8'h2D};

    localparam int MD_IDLE = 0;
    localparam int MD_ARM  = 1;
    localparam int MD_HELD = 2;
    localparam int MD_LOCK = 3;

    logic        clk256 = 1'b0;
    logic        reset  = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [7:0]  key;
    logic        key_down;
    logic [15:0] held = '0;

    int checks   = 0;
    int failures = 0;

    int          m_mode, m_pos, m_run, m_absent, m_held;
    logic [8:0]  steady;
    logic [8:0]  pend_q[$];
    logic        any_key, saw9;

    keypad_scanner #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_SCANS(DB),
        .STUCK_SCANS   (STK)
    ) dut (
        .clk256  (clk256),
        .reset   (reset),
        .row_n   (row_n),
        .col_n   (col_n),
        .key     (key),
        .key_down(key_down)
    );

    always #5 clk256 = ~clk256;

    // Passive keypad: a held key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_n[c])
                for (int r = 0; r < 4; r++)
                    if (held[c*4+r]) row_n[r] = 1'b0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task model_reset();
        m_mode   = MD_IDLE;
        m_pos    = 0;
        m_run    = 0;
        m_absent = 0;
        m_held   = 0;
        steady   = {1'b0, KP_INVALID};
        pend_q.delete();
    endtask

    task accept();
        m_mode   = MD_HELD;
        m_absent = 0;
        m_held   = 0;
        steady   = {1'b1, KC_TAB[m_pos]};
    endtask

    task start_release();
        pend_q.push_back({1'b0, KP_KEY_RELEASED});
        pend_q.push_back({1'b0, KC_TAB[m_pos]});
        steady = {1'b0, KP_INVALID};
    endtask

    // Applies the rules once per completed scan, given the keys held in it.
    task model_scan_end(input logic [15:0] s);
        int c;
        c = -1;
        case (m_mode)
            MD_IDLE: begin
                for (int b = 11; b >= 0; b--) if (s[b]) c = b;
                if (c >= 0) begin
                    m_pos = c;
                    m_run = 1;
                    if (m_run >= int'(DB)) accept();
                    else m_mode = MD_ARM;
                end
            end
            MD_ARM: begin
                if (s[m_pos]) begin
                    m_run++;
                    if (m_run >= int'(DB)) accept();
                end else begin
                    m_mode = MD_IDLE;
                end
            end
            MD_HELD: begin
                if (s[m_pos]) begin
                    if (m_absent > 0) begin
                        m_absent = 0;
                        m_held   = 0;
                    end else begin
                        m_held++;
`ifdef KPSCAN_STUCK_TIMEOUT_EN
                        if (m_held >= int'(STK)) begin
                            start_release();
                            m_mode = MD_LOCK;
                            m_run  = 0;
                        end
`endif
                    end
                end else begin
                    m_absent++;
                    if (m_absent >= int'(DB)) begin
                        start_release();
                        m_mode = MD_IDLE;
                    end
                end
            end
            default: begin
                if (s[m_pos]) m_run = 0;
                else begin
                    m_run++;
                    if (m_run >= int'(DB)) m_mode = MD_IDLE;
                end
            end
        endcase
    endtask

    // One full scan with a fixed set of held keys; checks every cycle.
    task run_scan(input logic [15:0] s);
        logic [8:0] exp;
        logic [3:0] one;
        held = s;
        for (int i = 1; i <= int'(NS); i++) begin
            @(posedge clk256);
            #1;
            if (i == int'(NS)) model_scan_end(s);
            exp = (pend_q.size() > 0) ? pend_q.pop_front() : steady;
            one = 4'b0001 << ((i / int'(ST)) % 4);
            check("key", key, exp[7:0]);
            check("key_down", {7'b0, key_down}, {7'b0, exp[8]});
            check("col_n", {4'b0, col_n}, {4'b0, ~one});
            if (key != KP_INVALID) any_key = 1'b1;
            if (key == KC_TAB[10]) saw9 = 1'b1;
        end
    endtask

    task do_reset();
        held  = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk256);
        @(negedge clk256);
        check("rst_col_n", {4'b0, col_n}, 8'h0E);
        check("rst_key", key, KP_INVALID);
        check("rst_key_down", {7'b0, key_down}, 8'h00);
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] s;
        any_key = 1'b0;
        saw9    = 1'b0;
        model_reset();
        do_reset();

        // Idle scans: column rotation checked in every cycle.
        run_scan('0);
        run_scan('0);

        // "5": col1 row1.
        repeat (4) run_scan(16'h0020);
        repeat (3) run_scan('0);

        // "7" bounce: present for a single scan only.
        any_key = 1'b0;
        run_scan(16'h0004);
        repeat (3) run_scan('0);
        check("bounce_silent", {7'b0, any_key}, 8'h00);

        // "1" held, "9" added and removed, then "1" released.
        saw9 = 1'b0;
        repeat (3) run_scan(16'h0001);
        repeat (3) run_scan(16'h0401);
        repeat (2) run_scan(16'h0001);
        repeat (3) run_scan('0);
        check("no_key9", {7'b0, saw9}, 8'h00);

        // "A" is unmapped.
        any_key = 1'b0;
        repeat (5) run_scan(16'h1000);
        run_scan('0);
        check("unmapped_silent", {7'b0, any_key}, 8'h00);

        // "#" -> KP_MINUS.
        repeat (3) run_scan(16'h0800);
        check("hash_code", key, KP_MINUS);
        repeat (3) run_scan('0);

        // Reset while "8" is PRESSED: immediate abort, no release codes.
        repeat (3) run_scan(16'h0040);
        check("pre_rst_key", key, KC_TAB[6]);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_key", key, KP_INVALID);
        check("async_rst_down", {7'b0, key_down}, 8'h00);
        check("async_rst_col", {4'b0, col_n}, 8'h0E);
        do_reset();
        repeat (2) run_scan('0);

`ifdef KPSCAN_STUCK_TIMEOUT_EN
        // "*" held long enough to time out, then lockout until released.
        repeat (3) run_scan(16'h0008);
        check("star_code", key, KP_STAR);
        repeat (6) run_scan(16'h0008);
        check("lockout_key", key, KP_INVALID);
        repeat (4) run_scan('0);
`endif

        // Random key patterns.
        s = '0;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: s = '0;
                1: s = 16'(1) << $urandom_range(0, 15);
                2: s = s | (16'(1) << $urandom_range(0, 15));
                default: ;
            endcase
            run_scan(s);
        end
        repeat (4) run_scan('0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
